// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter_pkg
//  Description : Shared encodings for the icache/dcache AXI read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        RD_BYTE = 3'b000,
        RD_HALF = 3'b001,
        RD_WORD = 3'b010,
        RD_LINE = 3'b100
    } rd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] c_burst_incr = 2'b01;

    // Clears the byte-offset-within-line bits of a physical address.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int off_bits);
        return addr & ~((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_grant.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_grant
//  Description : Dcache-priority winner select with icache anti-starvation.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic sel_i,
    output logic sel_d
);

    localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               w_force_i;

    // Once the icache has lost STARVE_LIMIT times in a row it wins outright.
    assign w_force_i = i_req && (r_starve_cnt == c_limit);
    assign sel_d     = grant_en && d_req && !w_force_i;
    assign sel_i     = grant_en && i_req && !sel_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (sel_d) begin
            if (!i_req)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != c_limit)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end else if (sel_i) begin
            r_starve_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter
//  Description : Shares one AXI AR/R channel between icache and dcache,
//                one transaction in flight, dcache priority with starvation guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS   = 4,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [3:0] I_ID         = 4'd0,
    parameter logic [3:0] D_ID         = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int         c_off_bits = $clog2(LINE_WORDS) + 2;
    localparam logic [7:0] c_line_len = 8'(LINE_WORDS - 1);

    state_e      r_state;
    state_e      w_state_nxt;

    logic        w_grant_en;
    logic        w_sel_i;
    logic        w_sel_d;
    logic        w_grant;
    logic [2:0]  w_req_type;
    logic [31:0] w_req_addr;

    logic        r_owner_d;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;

    logic        w_beat;
    logic        w_beat_ok;

    // ------------------------------------------------------------------
    // Arbitration: only open while idle and not held in reset.
    // ------------------------------------------------------------------
    assign w_grant_en = (r_state == ST_IDLE) && !reset;

    axi_rd_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_rd_req),
        .d_req    (d_rd_req),
        .grant_en (w_grant_en),
        .sel_i    (w_sel_i),
        .sel_d    (w_sel_d)
    );

    assign i_rd_rdy   = w_sel_i;
    assign d_rd_rdy   = w_sel_d;
    assign w_grant    = w_sel_i || w_sel_d;
    assign w_req_type = w_sel_d ? d_rd_type : i_rd_type;
    assign w_req_addr = w_sel_d ? d_rd_addr : i_rd_addr;

    // ------------------------------------------------------------------
    // AR fields are fixed at grant time so they stay stable until arready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_d <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
        end else if (w_grant) begin
            r_owner_d <= w_sel_d;
            r_arid    <= w_sel_d ? D_ID : I_ID;
            if (w_req_type == RD_LINE) begin
                r_araddr <= line_align(w_req_addr, c_off_bits);
                r_arlen  <= c_line_len;
                r_arsize <= 3'd2;
            end else begin
                r_araddr <= w_req_addr;
                r_arlen  <= 8'd0;
                r_arsize <= {1'b0, w_req_type[1:0]};
            end
        end
    end

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = c_burst_incr;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant)
                    w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (arready)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // R routing: zero-latency pass-through to the owning cache only.
    // ------------------------------------------------------------------
    assign w_beat    = (r_state == ST_DATA) && rvalid;
    assign w_beat_ok = w_beat && (rid == r_arid);

    assign i_ret_valid = w_beat_ok && !r_owner_d;
    assign d_ret_valid = w_beat_ok &&  r_owner_d;
    assign i_ret_last  = i_ret_valid && rlast;
    assign d_ret_last  = d_ret_valid && rlast;
    assign i_ret_data  = rdata;
    assign d_ret_data  = rdata;

    // A beat tagged for the other cache means the bridge broke ordering.
    a_rid_matches_owner: assert property (
        @(posedge clk) disable iff (reset)
        w_beat |-> (rid == r_arid)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_arbiter
//  Description : Randomised scoreboard bench for the AXI read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    localparam int         LINE_WORDS   = 4;
    localparam int         STARVE_LIMIT = 4;
    localparam logic [3:0] I_ID         = 4'd0;
    localparam logic [3:0] D_ID         = 4'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [2:0]  i_rd_type, d_rd_type;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;

    axi_rd_arbiter #(
        .LINE_WORDS   (LINE_WORDS),
        .STARVE_LIMIT (STARVE_LIMIT),
        .I_ID         (I_ID),
        .D_ID         (D_ID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_req    (i_rd_req),
        .i_rd_type   (i_rd_type),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_last  (i_ret_last),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_type   (d_rd_type),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_last  (d_ret_last),
        .d_ret_data  (d_ret_data),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct {
        bit          owner_d;
        logic [31:0] data;
        bit          last;
    } r_t;

    ar_t ar_exp[$];
    r_t  r_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending requests and the starvation tally.
    bit          i_pend = 0, d_pend = 0;
    logic [2:0]  i_type = 3'b010, d_type = 3'b010;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0;
    int          starve = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rand_type();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic drive_reqs();
        i_rd_req  = i_pend;
        i_rd_type = i_type;
        i_rd_addr = i_addr;
        d_rd_req  = d_pend;
        d_rd_type = d_type;
        d_rd_addr = d_addr;
    endtask

    task automatic maybe_arrive();
        if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1; i_type = rand_type(); i_addr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 1) == 1) begin
            d_pend = 1; d_type = rand_type(); d_addr = $urandom;
        end
    endtask

    // One complete arbitrated transaction; called at posedge+1 of an idle cycle.
    task automatic serve(input int ar_wait, input int gap_max, input bit seq,
                         input logic [31:0] base, input int abort_at, input bit arrivals);
        bit          win_d;
        logic [2:0]  t;
        logic [31:0] ad;
        int          nb;
        ar_t         a;
        r_t          r;
        win_d = d_pend && !(i_pend && starve == STARVE_LIMIT);
        t     = win_d ? d_type : i_type;
        ad    = win_d ? d_addr : i_addr;
        if (win_d)
            starve = i_pend ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
        else
            starve = 0;
        a.id = win_d ? D_ID : I_ID;
        if (t == 3'b100) begin
            a.addr = ad - (ad % (LINE_WORDS * 4));
            a.len  = 8'(LINE_WORDS - 1);
            a.size = 3'd2;
            nb     = LINE_WORDS;
        end else begin
            a.addr = ad;
            a.len  = 8'd0;
            a.size = {1'b0, t[1:0]};
            nb     = 1;
        end
        ar_exp.push_back(a);

        @(negedge clk);
        check("grant", 64'({i_rd_rdy, d_rd_rdy}), win_d ? 64'h1 : 64'h2);
        @(posedge clk); #1;
        if (win_d) d_pend = 0; else i_pend = 0;
        if (arrivals) maybe_arrive();
        drive_reqs();

        arready = (ar_wait == 0);
        for (int k = 0; k <= ar_wait; k++) begin
            @(negedge clk);
            check("arvalid", 64'(arvalid), 64'h1);
            check("rdy_in_addr", 64'({i_rd_rdy, d_rd_rdy}), 64'h0);
            @(posedge clk); #1;
            arready = (k + 1 == ar_wait);
        end

        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk);
                check("rdy_in_gap", 64'({i_rd_rdy, d_rd_rdy, rready}), 64'h1);
                @(posedge clk); #1;
            end
            rvalid = 1'b1;
            rid    = a.id;
            rdata  = seq ? base + 32'(b) : $urandom;
            rlast  = (b == nb - 1);
            if (b == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("reset_drop", 64'({arvalid, rready, i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy}), 64'h0);
                @(posedge clk); #1;
                reset  = 1'b0;
                rvalid = 1'b0;
                rlast  = 1'b0;
                starve = 0;
                return;
            end
            r.owner_d = win_d;
            r.data    = rdata;
            r.last    = rlast;
            r_exp.push_back(r);
            @(negedge clk);
            check("rdy_in_beat", 64'({i_rd_rdy, d_rd_rdy, rready}), 64'h1);
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
    endtask

    // AR monitor: fields must match the oldest outstanding expectation every cycle arvalid is up.
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (arvalid === 1'b1) begin
                if (ar_exp.size() == 0) begin
                    check("ar_unexpected", 64'(arvalid), 64'h0);
                end else begin
                    e = ar_exp[0];
                    check("ar_fields", 64'({arid, araddr, arlen, arsize, arburst}),
                          64'({e.id, e.addr, e.len, e.size, 2'b01}));
                    if (arready === 1'b1) void'(ar_exp.pop_front());
                end
            end
        end
    end

    // R monitor: every forwarded beat must match the scoreboard in order.
    initial begin
        r_t e;
        forever begin
            @(negedge clk);
            if (i_ret_valid === 1'b1 || d_ret_valid === 1'b1) begin
                check("ret_onehot", 64'(i_ret_valid && d_ret_valid), 64'h0);
                if (r_exp.size() == 0) begin
                    check("ret_unexpected", 64'({i_ret_valid, d_ret_valid}), 64'h0);
                end else begin
                    e = r_exp.pop_front();
                    check("ret_owner", 64'(d_ret_valid), 64'(e.owner_d));
                    check("ret_data", 64'(e.owner_d ? d_ret_data : i_ret_data), 64'(e.data));
                    check("ret_last", 64'(e.owner_d ? d_ret_last : i_ret_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        i_rd_type = 3'b010; d_rd_type = 3'b010;
        i_rd_addr = 32'h0;  d_rd_addr = 32'h0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = 32'h0;

        @(negedge clk);
        check("reset_ar", 64'({arid, araddr, arlen, arsize, arburst, arvalid, rready}), 64'h4);
        check("reset_rdy", 64'({i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid}), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        i_rd_req = 1'b0; d_rd_req = 1'b0;

        // icache line read, misaligned address, sequential data
        i_pend = 1; i_type = 3'b100; i_addr = 32'h1fc00014;
        drive_reqs();
        serve(0, 0, 1, 32'hA0, -1, 0);

        // simultaneous requests: dcache first, then icache the cycle after rlast
        i_pend = 1; i_type = 3'b010; i_addr = 32'h1fc00020;
        d_pend = 1; d_type = 3'b010; d_addr = 32'h00000100;
        drive_reqs();
        serve(1, 1, 0, 0, -1, 0);
        serve(0, 0, 0, 0, -1, 0);

        // held icache request against a continuous dcache stream
        i_pend = 1; i_type = 3'b100; i_addr = 32'h1fc00100;
        for (int n = 0; n < 5; n++) begin
            d_pend = 1; d_type = rand_type(); d_addr = $urandom;
            drive_reqs();
            serve(0, 0, 0, 0, -1, 0);
        end
        serve(0, 0, 0, 0, -1, 0);

        // arready held low for 5 cycles
        d_pend = 1; d_type = 3'b010; d_addr = 32'h00000200;
        drive_reqs();
        serve(5, 0, 0, 0, -1, 0);

        // dcache byte read, unaligned
        d_pend = 1; d_type = 3'b000; d_addr = 32'h00000103;
        drive_reqs();
        serve(0, 0, 0, 0, -1, 0);

        // reset during DATA after two beats, then a normal request
        i_pend = 1; i_type = 3'b100; i_addr = 32'h1fc00040;
        drive_reqs();
        serve(0, 0, 0, 0, 2, 0);
        d_pend = 1; d_type = 3'b001; d_addr = 32'h00000302;
        drive_reqs();
        serve(0, 1, 0, 0, -1, 0);

        for (int n = 0; n < 40; n++) begin
            maybe_arrive();
            if (!i_pend && !d_pend) begin
                d_pend = 1; d_type = rand_type(); d_addr = $urandom;
            end
            drive_reqs();
            serve($urandom_range(0, 3), 2, 0, 0, -1, 1);
        end
        i_pend = 0; d_pend = 0;
        drive_reqs();

        repeat (3) @(posedge clk);
        #1;
        check("ar_drained", 64'(ar_exp.size()), 64'h0);
        check("r_drained", 64'(r_exp.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
